firing_control: RTL

- Sequencing FSM for the firing datapath. Drives its 3-bit `control` opcode (RELOAD/HOLD/SHOT) from a raw trigger button and a reload request.
- Debounces the trigger and guarantees SHOT lasts exactly one cycle per press. Enforces a cooldown between shots and a timed reload.
- Sits between the board push-buttons and the datapath. Consumes the datapath's `RemainingShots`/`isShot` outputs.

---
 rtl/firing_control.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/firing_control.sv
// firing_control: sequencing FSM for the firing datapath.
// Turns a raw fire button and a reload request into the datapath
// opcode on `control` (RELOAD/HOLD/SHOT). It debounces the trigger,
// enforces a cooldown after every shot and times the reload.
// Build option: define FIRING_AUTO_RELOAD_EN to reload automatically
// when the magazine runs dry instead of parking in EMPTY.
module firing_control #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int RELOAD_CYCLES   = 16,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       trigger,
    input  logic       reload_req,
    input  logic [1:0] remaining_shots,
    input  logic       is_shot,
    output logic [2:0] control,
    output logic       shot_fired,
    output logic       dry_fire,
    output logic       reload_done,
    output logic       hit,
    output logic       busy
);

    localparam logic [2:0] CTL_RELOAD = 3'b000;
    localparam logic [2:0] CTL_HOLD   = 3'b001;
    localparam logic [2:0] CTL_SHOT   = 3'b011;

    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELOAD_LOAD = CNT_W'(RELOAD_CYCLES - 1);

`ifdef FIRING_AUTO_RELOAD_EN
    localparam logic AUTO_RELOAD = 1'b1;
`else
    localparam logic AUTO_RELOAD = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRE,
        S_COOL,
        S_EMPTY,
        S_RELOAD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             dry_next;
    logic             done_next;

    logic             trig_meta;
    logic             trig_sync;
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_level;
    logic             deb_level_d;
    logic             fire_req;

    logic             is_shot_d;

    // Two-flop synchronizer for the asynchronous fire button.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_meta <= 1'b0;
            trig_sync <= 1'b0;
        end else begin
            trig_meta <= trigger;
            trig_sync <= trig_meta;
        end
    end

    // Debouncer: the level follows the synced input only after it has
    // differed for DEBOUNCE_CYCLES consecutive cycles; press and release alike.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt     <= '0;
            deb_level   <= 1'b0;
            deb_level_d <= 1'b0;
        end else begin
            deb_level_d <= deb_level;
            if (trig_sync == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_level <= trig_sync;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // One fire request per debounced press.
    always_comb begin
        fire_req = deb_level & ~deb_level_d;
    end

    // Next-state, counter and pulse decisions; enable low overrides everything.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dry_next   = 1'b0;
        done_next  = 1'b0;
        if (!enable) begin
            state_next = S_IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fire_req) begin
                        if (remaining_shots != 2'd0) begin
                            state_next = S_FIRE;
                        end else begin
                            dry_next = 1'b1;
                            if (AUTO_RELOAD) begin
                                state_next = S_RELOAD;
                                cnt_next   = RELOAD_LOAD;
                            end else begin
                                state_next = S_EMPTY;
                            end
                        end
                    end else if (reload_req && (remaining_shots != 2'd3)) begin
                        state_next = S_RELOAD;
                        cnt_next   = RELOAD_LOAD;
                    end
                end
                S_FIRE: begin
                    state_next = S_COOL;
                    cnt_next   = COOL_LOAD;
                end
                S_COOL: begin
                    // Presses and reload requests during cooldown are dropped.
                    if (cnt != '0) begin
                        cnt_next = cnt - CNT_W'(1);
                    end else if (remaining_shots == 2'd0) begin
                        if (AUTO_RELOAD) begin
                            state_next = S_RELOAD;
                            cnt_next   = RELOAD_LOAD;
                        end else begin
                            state_next = S_EMPTY;
                        end
                    end else begin
                        state_next = S_IDLE;
                    end
                end
                S_EMPTY: begin
                    if (reload_req) begin
                        state_next = S_RELOAD;
                        cnt_next   = RELOAD_LOAD;
                    end else if (fire_req) begin
                        dry_next = 1'b1;
                    end
                end
                S_RELOAD: begin
                    if (cnt != '0) begin
                        cnt_next = cnt - CNT_W'(1);
                    end else begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // State, shared down-counter and registered event pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            dry_fire    <= 1'b0;
            reload_done <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            dry_fire    <= dry_next;
            reload_done <= done_next;
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        control    = CTL_HOLD;
        shot_fired = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_FIRE: begin
                control    = CTL_SHOT;
                shot_fired = 1'b1;
            end
            S_RELOAD: control = CTL_RELOAD;
            default:  control = CTL_HOLD;
        endcase
    end

    // Hit pulse on a rising edge of is_shot, independent of state and enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_shot_d <= 1'b0;
            hit       <= 1'b0;
        end else begin
            is_shot_d <= is_shot;
            hit       <= is_shot & ~is_shot_d;
        end
    end

endmodule
